// File: rtl/clock_pkg.sv
// Shared limits, widths and BCD helper for the time-of-day clock.
package clock_pkg;
  localparam int H_MAX  = 23;
  localparam int MS_MAX = 59;
  localparam int H_W    = 5;
  localparam int MS_W   = 6;

  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [3:0] t, u;
    t = 4'(v / 6'd10);
    u = 4'(v % 6'd10);
    return {t, u};
  endfunction
endpackage

// File: rtl/param_digital_clock_if.sv
// Preset/alarm controls in, BCD display and status pulses out.
interface param_digital_clock_if;
  import clock_pkg::*;
  logic            LOAD;
  logic [H_W-1:0]  LD_H;
  logic [MS_W-1:0] LD_M, LD_S;
  logic            MODE12;
  logic            ALM_EN;
  logic [H_W-1:0]  ALM_H;
  logic [MS_W-1:0] ALM_M;
  logic [3:0]      Hh, Hl, Mh, Ml, Sh, Sl;
  logic            PM, SEC_TICK, isFull, ALARM, LD_ERR;

  modport master (output LOAD, LD_H, LD_M, LD_S, MODE12, ALM_EN, ALM_H, ALM_M,
                  input  Hh, Hl, Mh, Ml, Sh, Sl, PM, SEC_TICK, isFull, ALARM, LD_ERR);
  modport slave  (input  LOAD, LD_H, LD_M, LD_S, MODE12, ALM_EN, ALM_H, ALM_M,
                  output Hh, Hl, Mh, Ml, Sh, Sl, PM, SEC_TICK, isFull, ALARM, LD_ERR);
endinterface

// File: rtl/mod_counter.sv
// Wrap-around 0..MAX counter; co flags the increment that wraps back to zero.
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         co
);
  assign co = inc && (q == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr)  q <= '0;
    else if (ld)     q <= ld_val;
    else if (inc)    q <= co ? '0 : q + 1'b1;
  end
endmodule

// File: rtl/param_digital_clock.sv
// H:M:S clock with prescaler, preset load, 12/24 h display, hour pulse and one-shot alarm.
module param_digital_clock
  import clock_pkg::*;
#(
  parameter int DIV     = 50_000_000,
  parameter int ALM_LEN = 60
) (
  input logic CLK,
  input logic RST,
  param_digital_clock_if.slave bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]   pre;
  logic [MS_W-1:0] s, m;
  logic [H_W-1:0]  h, h_disp;
  logic            range_ok, ld_ok, tick, s_co, m_co, h_co;
  logic [MS_W-1:0] m_nx;
  logic [H_W-1:0]  h_nx;
  logic            alm_hit;
  logic            sec_tick, is_full, ld_err, alarm;
  logic [7:0]      arem;
  logic [7:0]      bcd_h, bcd_m, bcd_s;

  assign range_ok = (bus.LD_H <= H_W'(H_MAX)) && (bus.LD_M <= MS_W'(MS_MAX)) &&
                    (bus.LD_S <= MS_W'(MS_MAX));
  assign ld_ok    = bus.LOAD && range_ok;
  // Any LOAD, accepted or rejected, suppresses the tick.
  assign tick     = !bus.LOAD && (pre == PW'(DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST)            pre <= '0;
    else if (ld_ok)     pre <= '0;
    else if (bus.LOAD)  pre <= pre;
    else if (tick)      pre <= '0;
    else                pre <= pre + 1'b1;
  end

  mod_counter #(.MAX(MS_MAX), .W(MS_W)) u_sec (
    .clk(CLK), .rst(RST), .clr(1'b0), .ld(ld_ok), .ld_val(bus.LD_S),
    .inc(tick), .q(s), .co(s_co));
  mod_counter #(.MAX(MS_MAX), .W(MS_W)) u_min (
    .clk(CLK), .rst(RST), .clr(1'b0), .ld(ld_ok), .ld_val(bus.LD_M),
    .inc(s_co), .q(m), .co(m_co));
  mod_counter #(.MAX(H_MAX), .W(H_W)) u_hr (
    .clk(CLK), .rst(RST), .clr(1'b0), .ld(ld_ok), .ld_val(bus.LD_H),
    .inc(m_co), .q(h), .co(h_co));

  // Time after this tick, used to match the alarm at S==0 without waiting a cycle.
  assign m_nx    = m_co ? '0 : m + 1'b1;
  assign h_nx    = h_co ? '0 : (m_co ? h + 1'b1 : h);
  assign alm_hit = s_co && bus.ALM_EN && (m_nx == bus.ALM_M) && (h_nx == bus.ALM_H);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sec_tick <= 1'b0;
      is_full  <= 1'b0;
      ld_err   <= 1'b0;
    end else begin
      sec_tick <= tick;
      is_full  <= m_co;
      ld_err   <= bus.LOAD && !range_ok;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || !bus.ALM_EN) begin
      alarm <= 1'b0;
      arem  <= '0;
    end else if (alm_hit) begin
      alarm <= 1'b1;
      arem  <= 8'(ALM_LEN);
    end else if (tick && alarm) begin
      if (arem == 8'd1) alarm <= 1'b0;
      arem <= arem - 8'd1;
    end
  end

  always_comb begin
    h_disp = h;
    if (bus.MODE12) begin
      if (h == '0)                 h_disp = H_W'(12);
      else if (h > H_W'(12))       h_disp = h - H_W'(12);
    end
  end

  assign bcd_h = bin2bcd({1'b0, h_disp});
  assign bcd_m = bin2bcd(m);
  assign bcd_s = bin2bcd(s);

  assign bus.Hh       = bcd_h[7:4];
  assign bus.Hl       = bcd_h[3:0];
  assign bus.Mh       = bcd_m[7:4];
  assign bus.Ml       = bcd_m[3:0];
  assign bus.Sh       = bcd_s[7:4];
  assign bus.Sl       = bcd_s[3:0];
  assign bus.PM       = (h >= H_W'(12));
  assign bus.SEC_TICK = sec_tick;
  assign bus.isFull   = is_full;
  assign bus.ALARM    = alarm;
  assign bus.LD_ERR   = ld_err;
endmodule

// File: tb/tb_param_digital_clock.sv
// Directed + randomized bench for param_digital_clock against a seconds-of-day model.
module tb_param_digital_clock;
  localparam int DIV = 4;
  localparam int ALM_LEN = 3;

  logic CLK = 1'b0;
  logic RST;
  param_digital_clock_if bus ();

  param_digital_clock #(.DIV(DIV), .ALM_LEN(ALM_LEN)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference: time as seconds since midnight, prescaler phase, alarm ticks remaining.
  int t, ph, arem;
  bit alarm_m, sec_m, full_m, err_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit tk, hit;
    int lh, lm, ls;
    tk = 0; hit = 0;
    lh = int'(bus.LD_H); lm = int'(bus.LD_M); ls = int'(bus.LD_S);
    if (RST) begin
      t = 0; ph = 0; alarm_m = 0; arem = 0; sec_m = 0; full_m = 0; err_m = 0;
    end else begin
      sec_m = 0; full_m = 0; err_m = 0;
      if (bus.LOAD) begin
        if (lh <= 23 && lm <= 59 && ls <= 59) begin
          t = lh * 3600 + lm * 60 + ls;
          ph = 0;
        end else err_m = 1;
      end else if (ph == DIV - 1) begin
        ph = 0;
        t = (t + 1) % 86400;
        tk = 1; sec_m = 1;
        full_m = (t % 3600 == 0);
        hit = bus.ALM_EN && (t == int'(bus.ALM_H) * 3600 + int'(bus.ALM_M) * 60);
      end else ph++;
      if (!bus.ALM_EN) begin
        alarm_m = 0; arem = 0;
      end else if (hit) begin
        alarm_m = 1; arem = ALM_LEN;
      end else if (tk && alarm_m) begin
        arem--;
        if (arem == 0) alarm_m = 0;
      end
    end
  endtask

  task automatic check_all();
    int hh, mm, ss, hd;
    hh = t / 3600; mm = (t / 60) % 60; ss = t % 60;
    hd = hh;
    if (bus.MODE12) hd = (hh == 0) ? 12 : (hh > 12 ? hh - 12 : hh);
    check("Hh", bus.Hh, hd / 10);
    check("Hl", bus.Hl, hd % 10);
    check("Mh", bus.Mh, mm / 10);
    check("Ml", bus.Ml, mm % 10);
    check("Sh", bus.Sh, ss / 10);
    check("Sl", bus.Sl, ss % 10);
    check("PM", bus.PM, hh >= 12);
    check("SEC_TICK", bus.SEC_TICK, sec_m);
    check("isFull", bus.isFull, full_m);
    check("ALARM", bus.ALARM, alarm_m);
    check("LD_ERR", bus.LD_ERR, err_m);
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    check_all();
  endtask

  task automatic load(input int hh, input int mm, input int ss);
    bus.LOAD = 1'b1;
    bus.LD_H = 5'(hh); bus.LD_M = 6'(mm); bus.LD_S = 6'(ss);
    step();
    bus.LOAD = 1'b0;
  endtask

  initial begin
    int n, first, last, lim;
    RST = 1'b1;
    bus.LOAD = 1'b0; bus.LD_H = '0; bus.LD_M = '0; bus.LD_S = '0;
    bus.MODE12 = 1'b0; bus.ALM_EN = 1'b0; bus.ALM_H = '0; bus.ALM_M = '0;
    t = 0; ph = 0; arem = 0; alarm_m = 0; sec_m = 0; full_m = 0; err_m = 0;
    #2;

    // 1: reset, then free run
    step(); step();
    bus.MODE12 = 1'b1; #1; check_all(); bus.MODE12 = 1'b0; #1;
    RST = 1'b0;
    n = 0; first = -1; last = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.SEC_TICK) begin n++; if (first < 0) first = i; last = i; end
    end
    check("tick_count", n, 3);
    check("tick_first", first, 4);
    check("tick_spacing", last - first, 8);
    check("run_Sl", bus.Sl, 3);

    // 2: midnight rollover
    load(23, 59, 58);
    n = 0;
    for (int i = 0; i < 8; i++) begin step(); if (bus.isFull) n++; end
    check("full_count", n, 1);
    check("midnight_Hl", bus.Hl, 0);

    // 3: rejected load and 12 h display
    load(23, 60, 0);
    check("lderr_pulse", bus.LD_ERR, 1);
    check("lderr_hold_Sl", bus.Sl, 0);
    step();
    check("lderr_clear", bus.LD_ERR, 0);
    bus.MODE12 = 1'b1;
    load(13, 5, 0);
    check("m12_13_Hh", bus.Hh, 0);
    check("m12_13_Hl", bus.Hl, 1);
    check("m12_13_PM", bus.PM, 1);
    load(0, 10, 0);
    check("m12_00_Hh", bus.Hh, 1);
    check("m12_00_Hl", bus.Hl, 2);
    check("m12_00_PM", bus.PM, 0);
    bus.MODE12 = 1'b0;

    // 4: alarm length and early disarm
    bus.ALM_EN = 1'b1; bus.ALM_H = 5'd7; bus.ALM_M = 6'd30;
    load(7, 29, 59);
    n = 0;
    for (int i = 0; i < 24; i++) begin step(); if (bus.ALARM) n++; end
    check("alarm_cycles", n, 3 * DIV);
    load(7, 29, 59);
    for (int i = 0; i < DIV; i++) step();
    check("alarm_rise", bus.ALARM, 1);
    for (int i = 0; i < DIV; i++) step();
    bus.ALM_EN = 1'b0;
    step();
    check("alarm_disarm", bus.ALARM, 0);
    bus.ALM_EN = 1'b1;

    // 5: load on a tick cycle
    lim = 0;
    while (ph != DIV - 1 && lim < 2 * DIV) begin step(); lim++; end
    check("tick_phase_found", ph, DIV - 1);
    load(10, 20, 30);
    check("ldtick_no_tick", bus.SEC_TICK, 0);
    check("ldtick_Sl", bus.Sl, 0);
    n = 0;
    do begin step(); n++; end while (!bus.SEC_TICK && n < 3 * DIV);
    check("ldtick_next", n, DIV);

    // 6: reset while alarm is active
    bus.ALM_H = 5'd12; bus.ALM_M = 6'd34;
    load(12, 33, 59);
    for (int i = 0; i < DIV; i++) step();
    load(12, 34, 56);
    check("pre_rst_alarm", bus.ALARM, 1);
    RST = 1'b1;
    step();
    check("rst_alarm", bus.ALARM, 0);
    check("rst_Ml", bus.Ml, 0);
    RST = 1'b0;
    n = 0;
    do begin step(); n++; end while (!bus.SEC_TICK && n < 3 * DIV);
    check("rst_next_tick", n, DIV);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 149) == 0);
      bus.LOAD = ($urandom_range(0, 24) == 0);
      bus.LD_H = 5'($urandom_range(0, 25));
      bus.LD_M = 6'($urandom_range(0, 61));
      bus.LD_S = 6'($urandom_range(0, 3) == 0 ? $urandom_range(0, 61) : $urandom_range(55, 61));
      if (bus.LOAD && $urandom_range(0, 1) == 1) begin
        bus.ALM_H = bus.LD_H;
        bus.ALM_M = (bus.LD_M == 6'd59) ? 6'd0 : bus.LD_M + 6'd1;
      end
      bus.MODE12 = 1'($urandom_range(0, 1));
      bus.ALM_EN = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
